// File: rtl/bus_xfer_pkg.sv
// Shared codes, sizes and types for the bus transfer sequencer.
// The optional FIFO bypass is enabled by defining BUS_XFER_BYPASS_EN.
package bus_xfer_pkg;

  localparam int unsigned SRC_COUNT = 20;
  localparam int unsigned DST_COUNT = 21;
  localparam int unsigned CODE_W    = 5;

  // Source codes (bus drivers)
  localparam logic [CODE_W-1:0] SRC_RZ  = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R0  = 5'd1;
  localparam logic [CODE_W-1:0] SRC_R15 = 5'd16;
  localparam logic [CODE_W-1:0] SRC_HI  = 5'd17;
  localparam logic [CODE_W-1:0] SRC_LO  = 5'd18;
  localparam logic [CODE_W-1:0] SRC_MDR = 5'd19;

  // Destination codes (register loads)
  localparam logic [CODE_W-1:0] DST_R0  = 5'd0;
  localparam logic [CODE_W-1:0] DST_R15 = 5'd15;
  localparam logic [CODE_W-1:0] DST_HI  = 5'd16;
  localparam logic [CODE_W-1:0] DST_LO  = 5'd17;
  localparam logic [CODE_W-1:0] DST_Y   = 5'd18;
  localparam logic [CODE_W-1:0] DST_MAR = 5'd19;
  localparam logic [CODE_W-1:0] DST_MDR = 5'd20;

  typedef enum logic [1:0] {
    StIdle,
    StMemWait,
    StDrive
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;
    logic              rd;
  } xfer_t;

  // A memory read only makes sense when the MDR is the source being driven.
  function automatic logic req_is_valid(input logic [CODE_W-1:0] src,
                                        input logic [CODE_W-1:0] dst,
                                        input logic              rd);
    return (src <= SRC_MDR) && (dst <= DST_MDR) && (!rd || (src == SRC_MDR));
  endfunction

endpackage

// File: rtl/bus_xfer_fifo.sv
// Request FIFO for the bus transfer sequencer; DEPTH must be a power of two.
// Simultaneous push and pop are both honoured, even when full.
module bus_xfer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_pop_en  = pop && !empty;
  assign w_push_en = push && (!full || w_pop_en);
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_seq.sv
// Bus transfer sequencer: queues {src, dst, rd} requests and drives one-hot
// bus/load enables, optionally after a memory read. Define BUS_XFER_BYPASS_EN
// to let a plain request reach DRIVE one cycle earlier when nothing is pending.
module bus_xfer_seq
  import bus_xfer_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CODE_W-1:0]    req_src,
  input  logic [CODE_W-1:0]    req_dst,
  input  logic                 req_rd,
  output logic [SRC_COUNT-1:0] src_out,
  output logic [DST_COUNT-1:0] dst_in,
  output logic                 mem_read,
  input  logic                 mem_done,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam int unsigned   TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CODE_W-1:0] r_src;
  logic [CODE_W-1:0] w_src_nxt;
  logic [CODE_W-1:0] r_dst;
  logic [CODE_W-1:0] w_dst_nxt;
  logic [TW-1:0]     r_tmo;
  logic [TW-1:0]     w_tmo_nxt;
  logic [1:0]        r_err;
  logic [1:0]        w_err_nxt;

  xfer_t w_req;
  xfer_t w_head;
  logic  w_accept;
  logic  w_req_ok;
  logic  w_bypass;
  logic  w_push;
  logic  w_pop;
  logic  w_fifo_full;
  logic  w_fifo_empty;

  assign w_req     = '{src: req_src, dst: req_dst, rd: req_rd};
  assign req_ready = !w_fifo_full;
  assign w_accept  = req_valid && req_ready;
  assign w_req_ok  = req_is_valid(req_src, req_dst, req_rd);

`ifdef BUS_XFER_BYPASS_EN
  assign w_bypass = w_accept && w_req_ok && !req_rd && (r_state == StIdle) && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && w_req_ok && !w_bypass;

  bus_xfer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(xfer_t))
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (w_push),
    .push_data (w_req),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_pop       = 1'b0;

    if (w_accept && !w_req_ok) begin
      w_err_nxt[0] = 1'b1;
    end

    case (r_state)
      StIdle, StDrive: begin
        // Leaving DRIVE goes straight to the next entry so back-to-back
        // transfers drive on consecutive cycles.
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_src_nxt   = w_head.src;
          w_dst_nxt   = w_head.dst;
          w_tmo_nxt   = '0;
          w_state_nxt = w_head.rd ? StMemWait : StDrive;
        end else if (w_bypass) begin
          w_src_nxt   = req_src;
          w_dst_nxt   = req_dst;
          w_state_nxt = StDrive;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StMemWait: begin
        if (mem_done) begin
          w_state_nxt = StDrive;
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt[1] = 1'b1;
          w_state_nxt  = StIdle;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Enables decode from registered state so clr removes them combinationally.
  always_comb begin
    src_out = '0;
    dst_in  = '0;
    if (r_state == StDrive) begin
      for (int i = 0; i < SRC_COUNT; i++) begin
        src_out[i] = (r_src == CODE_W'(i));
      end
      for (int i = 0; i < DST_COUNT; i++) begin
        dst_in[i] = (r_dst == CODE_W'(i));
      end
    end
  end

  assign mem_read = (r_state == StMemWait);
  assign busy     = (r_state != StIdle) || !w_fifo_empty;
  assign err      = r_err;

  a_src_onehot0 : assert property (@(posedge clk) disable iff (clr) $onehot0(src_out));
  a_dst_onehot0 : assert property (@(posedge clk) disable iff (clr) $onehot0(dst_in));
  a_pair_drive  : assert property (@(posedge clk) disable iff (clr)
                                   ((src_out == '0) == (dst_in == '0)));

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: directed scenarios plus randomized traffic, all
// checked each cycle against a queue-based transaction model.
module tb_bus_xfer_seq;

  localparam int Depth   = 4;
  localparam int Timeout = 15;
`ifdef BUS_XFER_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic        req_rd;
  logic [19:0] src_out;
  logic [20:0] dst_in;
  logic        mem_read;
  logic        mem_done;
  logic        busy;
  logic [1:0]  err;

  bus_xfer_seq #(
    .DEPTH       (Depth),
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_rd    (req_rd),
    .src_out   (src_out),
    .dst_in    (dst_in),
    .mem_read  (mem_read),
    .mem_done  (mem_done),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending queue plus what the current transfer is doing.
  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic       rd;
  } ent_t;

  ent_t       q[$];
  int         m_phase;   // 0 nothing, 1 awaiting memory, 2 driving the bus
  int         m_waited;
  logic [4:0] m_src;
  logic [4:0] m_dst;
  logic [1:0] m_err;

  task automatic model_reset();
    q.delete();
    m_phase  = 0;
    m_waited = 0;
    m_src    = '0;
    m_dst    = '0;
    m_err    = '0;
  endtask

  task automatic begin_xfer(input ent_t e);
    m_src    = e.src;
    m_dst    = e.dst;
    m_waited = 0;
    m_phase  = e.rd ? 1 : 2;
  endtask

  task automatic model_step();
    bit   acc, ok, byp;
    ent_t e;
    if (clr) return;
    acc = req_valid && (q.size() < Depth);
    ok  = (req_src <= 5'd19) && (req_dst <= 5'd20) && (!req_rd || req_src == 5'd19);
    byp = 1'b0;
    e   = '{src: req_src, dst: req_dst, rd: req_rd};
    case (m_phase)
      1: begin
        if (mem_done) m_phase = 2;
        else if (m_waited + 1 >= Timeout) begin
          m_err[1] = 1'b1;
          m_phase  = 0;
        end else m_waited++;
      end
      default: begin
        if (q.size() > 0) begin_xfer(q.pop_front());
        else if (Bypass && m_phase == 0 && acc && ok && !req_rd) begin
          byp = 1'b1;
          begin_xfer(e);
        end else m_phase = 0;
      end
    endcase
    if (acc && !ok) m_err[0] = 1'b1;
    if (acc && ok && !byp) q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [19:0] one20;
    logic [20:0] one21;
    logic [19:0] es;
    logic [20:0] ed;
    one20 = 20'd1;
    one21 = 21'd1;
    es = (m_phase == 2) ? (one20 << m_src) : '0;
    ed = (m_phase == 2) ? (one21 << m_dst) : '0;
    chk("src_out", 32'(src_out), 32'(es));
    chk("dst_in", 32'(dst_in), 32'(ed));
    chk("mem_read", 32'(mem_read), 32'(m_phase == 1));
    chk("req_ready", 32'(req_ready), 32'(q.size() < Depth));
    chk("busy", 32'(busy), 32'(m_phase != 0 || q.size() > 0));
    chk("err", 32'(err), 32'(m_err));
  end

  task automatic step(input logic v, input logic [4:0] s, input logic [4:0] d,
                      input logic rd, input logic done);
    req_valid = v;
    req_src   = s;
    req_dst   = d;
    req_rd    = rd;
    mem_done  = done;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    model_reset();
    #1;
    chk("clr_ready", 32'(req_ready), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    idle();
    clr = 1'b0;
  endtask

  initial begin
    clr       = 1'b1;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    req_rd    = 1'b0;
    mem_done  = 1'b0;
    model_reset();
    #1;
    chk("rst_src_out", 32'(src_out), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    idle();
    clr = 1'b0;

    // R4 -> Y, no read
    do_clr();
    step(1'b1, 5'd5, 5'd18, 1'b0, 1'b0);
    if (!Bypass) begin
      chk("r4y_early", 32'(src_out), 32'd0);
      idle();
    end
    chk("r4y_src", 32'(src_out), 32'h00020);
    chk("r4y_dst", 32'(dst_in), 32'h40000);
    idle();
    chk("r4y_once", 32'(src_out), 32'd0);

    // MDR -> R3 with a read completing in the fourth wait cycle
    do_clr();
    step(1'b1, 5'd19, 5'd3, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait", 32'(mem_read), 32'd1);
      step(1'b0, 5'd0, 5'd0, 1'b0, i == 3);
    end
    chk("rd_src", 32'(src_out), 32'h80000);
    chk("rd_dst", 32'(dst_in), 32'h8);
    chk("rd_memread_off", 32'(mem_read), 32'd0);
    idle();
    chk("rd_once", 32'(src_out), 32'd0);

    // Memory never answers
    do_clr();
    step(1'b1, 5'd19, 5'd7, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < Timeout; i++) begin
      chk("tmo_wait", 32'(mem_read), 32'd1);
      idle();
    end
    chk("tmo_err", 32'(err), 32'd2);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_nodrive", 32'(src_out), 32'd0);

    // Invalid code is dropped, later traffic still runs
    do_clr();
    step(1'b1, 5'd25, 5'd2, 1'b0, 1'b0);
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_notq", 32'(busy), 32'd0);
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
    idle();
    idle();
    chk("inv_err_sticky", 32'(err), 32'd1);

    // Fill the FIFO behind a pending read, then drain back-to-back
    do_clr();
    step(1'b1, 5'd19, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd1, 5'd10, 1'b0, 1'b0);
    step(1'b1, 5'd2, 5'd11, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd12, 1'b0, 1'b0);
    step(1'b1, 5'd4, 5'd13, 1'b0, 1'b0);
    chk("full_ready", 32'(req_ready), 32'd0);
    step(1'b1, 5'd5, 5'd14, 1'b0, 1'b1);
    chk("drain_mdr", 32'(src_out), 32'h80000);
    step(1'b1, 5'd5, 5'd14, 1'b0, 1'b0);
    chk("drain_1", 32'(src_out), 32'h2);
    step(1'b1, 5'd5, 5'd14, 1'b0, 1'b0);
    chk("drain_2", 32'(src_out), 32'h4);
    idle();
    chk("drain_3", 32'(src_out), 32'h8);
    idle();
    chk("drain_4", 32'(src_out), 32'h10);
    idle();
    chk("drain_5", 32'(src_out), 32'h20);
    chk("drain_5_dst", 32'(dst_in), 32'h4000);
    idle();
    chk("drain_done", 32'(busy), 32'd0);

    // clr in the middle of a memory wait
    do_clr();
    step(1'b1, 5'd19, 5'd4, 1'b1, 1'b0);
    step(1'b1, 5'd2, 5'd5, 1'b0, 1'b0);
    idle();
    clr = 1'b1;
    model_reset();
    #1;
    chk("abort_memread", 32'(mem_read), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    idle();
    clr = 1'b0;
    idle();
    idle();
    chk("abort_nodrive", 32'(src_out), 32'd0);

    // Randomized traffic
    do_clr();
    for (int k = 0; k < 3000; k++) begin
      logic       v, rd, done;
      logic [4:0] s, d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      d = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
      if (s == 5'd19) rd = 1'($urandom_range(0, 1));
      else rd = ($urandom_range(0, 19) == 0);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b1;
        model_reset();
      end
      step(v, s, d, rd, done);
      clr = 1'b0;
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_xfer_seq.md
BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth, a power of two of at least 2.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum cycles to wait for mem_done.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  transfer request offered.
REQ-006 req_ready  out  1  request can be accepted; equals !fifo_full.
REQ-007 req_src  in  5  source code: 0=RZ, 1..16=R0..R15, 17=HI, 18=LO, 19=MDR.
REQ-008 req_dst  in  5  destination code: 0..15=R0..R15, 16=HI, 17=LO, 18=Y, 19=MAR, 20=MDR.
REQ-009 req_rd  in  1  perform a memory read before driving the MDR source.
REQ-010 src_out  out  20  one-hot bus-driver enables; bit i = source code i.
REQ-011 dst_in  out  21  one-hot register load enables; bit i = destination code i.
REQ-012 mem_read  out  1  memory read strobe, held high while waiting.
REQ-013 mem_done  in  1  memory read complete, one-cycle pulse.
REQ-014 busy  out  1  high when not IDLE or FIFO not empty.
REQ-015 err  out  2  sticky errors: bit0 = invalid code, bit1 = memory timeout.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high.
REQ-017 An accepted request with req_src>19, req_dst>20, or req_rd=1 with req_src!=19 SHALL be discarded and SHALL set err[0].
REQ-018 Valid requests SHALL be queued in FIFO order, {src, dst, rd}.
REQ-019 States SHALL be IDLE, MEMWAIT and DRIVE.
REQ-020 From IDLE with the FIFO non-empty, the head SHALL be popped: to MEMWAIT if rd=1, otherwise to DRIVE.
REQ-021 In MEMWAIT, mem_read SHALL be high; mem_done SHALL move the FSM to DRIVE.
REQ-022 If mem_done is absent for MEM_TIMEOUT cycles in MEMWAIT, the FSM SHALL set err[1], drop the transfer and return to IDLE.
REQ-023 DRIVE SHALL last exactly one cycle, asserting src_out[src] and dst_in[dst] together; all other bits SHALL be zero.
REQ-024 After DRIVE, the FSM SHALL pop the next entry directly, with no idle bubble, when the FIFO is non-empty; otherwise it SHALL go to IDLE.
REQ-025 src_out and dst_in SHALL be all-zero in IDLE and MEMWAIT and SHALL never have more than one bit set.
REQ-026 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-027 Minimum latency without bypass: accepted at edge N, DRIVE in cycle N+2, i.e. one cycle in FIFO then pop.
REQ-028 err SHALL clear only on clr.

Reset
REQ-029 clr SHALL immediately force IDLE, empty the FIFO, clear the timeout counter, and zero src_out, dst_in, mem_read and err.
REQ-030 clr asserted during MEMWAIT or DRIVE SHALL abort the transfer with no partial enables.
REQ-031 After clr, req_ready=1 and busy=0.

Configuration
REQ-032 Macro BUS_XFER_BYPASS_EN: when defined, a valid request with rd=0 that arrives in IDLE with the FIFO empty SHALL skip the FIFO, and DRIVE SHALL occur in cycle N+1.
REQ-033 Without BUS_XFER_BYPASS_EN, every request SHALL pass through the FIFO (REQ-027 latency).

Structure
REQ-034 Package bus_xfer_pkg SHALL hold the source and destination code constants, SRC_COUNT=20, DST_COUNT=21 and the FSM state typedef.
REQ-035 The FIFO SHALL be the sub-module bus_xfer_fifo (parameter DEPTH, push/pop/full/empty).

Verification
REQ-036 src=5 (R4), dst=18 (Y), rd=0 -> one DRIVE cycle with src_out=20'h00020, dst_in=21'h40000, at cycle N+2 (N+1 with bypass).
REQ-037 src=19, dst=3, rd=1, mem_done 4 cycles later -> mem_read high 4 cycles, then one DRIVE cycle with src_out bit19 and dst_in bit3.
REQ-038 rd=1, mem_done never -> err=2'b10 after 15 MEMWAIT cycles, no DRIVE, FSM back in IDLE.
REQ-039 src=25 -> not queued, err[0]=1; following valid requests still execute.
REQ-040 Five back-to-back requests with DEPTH=4 -> req_ready drops while full, all five DRIVE in order on consecutive cycles.
REQ-041 clr pulsed mid-MEMWAIT -> mem_read=0 immediately, FIFO empty, busy=0, no enable ever asserted.
